// File: rtl/raster_to_block_tx_pkg.sv
// Shared geometry and pixel types for the raster-to-block transmit path.
package raster_to_block_tx_pkg;
  localparam int unsigned BLK           = 8;
  localparam int unsigned IMG_W         = 48;
  localparam int unsigned IMG_H         = 32;
  localparam int unsigned PIX_W         = 8;
  localparam int unsigned BLK_PER_ROW   = IMG_W / BLK;
  localparam int unsigned BLK_PER_FRAME = BLK_PER_ROW * (IMG_H / BLK);
  localparam int unsigned STRIP_DEPTH   = BLK * IMG_W;

  typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/raster_to_block_tx_strip_buf_2bank.sv
// Two-bank strip storage: synchronous write port, asynchronous read port.
module raster_to_block_tx_strip_buf_2bank #(
  parameter int unsigned Depth = 384,
  parameter int unsigned PixW  = 8,
  localparam int unsigned AW   = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic            wbank_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [PixW-1:0] wdata_i,
  input  logic            rbank_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [PixW-1:0] rdata_o
);
  logic [PixW-1:0] mem_q [2][Depth];

  // Contents are intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wbank_i][waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rbank_i][raddr_i];
endmodule

// File: rtl/raster_to_block_tx.sv
// Reorders a raster pixel stream into 8x8 block order using a ping-pong strip buffer.
module raster_to_block_tx #(
  parameter int unsigned IMG_W = raster_to_block_tx_pkg::IMG_W,
  parameter int unsigned IMG_H = raster_to_block_tx_pkg::IMG_H,
  parameter int unsigned BLK   = raster_to_block_tx_pkg::BLK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_pix,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_pix,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_first,
  output logic       out_last,
  output logic [4:0] out_blk,
  output logic       frame_done
);
  import raster_to_block_tx_pkg::*;

  localparam int unsigned BlkPerRow   = IMG_W / BLK;
  localparam int unsigned BlkPerFrame = BlkPerRow * (IMG_H / BLK);
  localparam int unsigned Depth       = BLK * IMG_W;
  localparam int unsigned AW          = $clog2(Depth);
  localparam int unsigned RowW        = $clog2(BLK);
  localparam int unsigned ColW        = $clog2(IMG_W);
  localparam int unsigned BcW         = (BlkPerRow > 1) ? $clog2(BlkPerRow) : 1;

  typedef logic [AW-1:0] addr_t;

  logic [1:0]      full_q, full_d;
  logic            wbank_q, wbank_d, rbank_q, rbank_d;
  logic [RowW-1:0] wr_row_q, wr_row_d, rd_row_q, rd_row_d;
  logic [ColW-1:0] wr_col_q, wr_col_d;
  logic [RowW-1:0] rd_col_q, rd_col_d;
  logic [BcW-1:0]  blk_col_q, blk_col_d;
  logic [4:0]      blk_cnt_q, blk_cnt_d;
  pix_t            out_pix_q, out_pix_d;
  logic            out_valid_q, out_valid_d, out_first_q, out_first_d;
  logic            out_last_q, out_last_d, frame_done_q, frame_done_d;
  logic [4:0]      out_blk_q, out_blk_d;

  logic  in_fire, wr_last, rd_load, rd_blk_end, rd_strip_end;
  addr_t waddr, raddr;
  pix_t  rdata;

  assign waddr = addr_t'(wr_row_q) * addr_t'(IMG_W) + addr_t'(wr_col_q);
  assign raddr = addr_t'(rd_row_q) * addr_t'(IMG_W) + addr_t'(blk_col_q) * addr_t'(BLK)
               + addr_t'(rd_col_q);

  raster_to_block_tx_strip_buf_2bank #(
    .Depth (Depth),
    .PixW  (PIX_W)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (in_fire),
    .wbank_i (wbank_q),
    .waddr_i (waddr),
    .wdata_i (in_pix),
    .rbank_i (rbank_q),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    in_ready     = !full_q[wbank_q];
    in_fire      = in_valid && in_ready;
    wr_last      = (wr_row_q == RowW'(BLK - 1)) && (wr_col_q == ColW'(IMG_W - 1));
    rd_load      = full_q[rbank_q] && (!out_valid_q || out_ready);
    rd_blk_end   = (rd_row_q == RowW'(BLK - 1)) && (rd_col_q == RowW'(BLK - 1));
    rd_strip_end = rd_blk_end && (blk_col_q == BcW'(BlkPerRow - 1));

    full_d       = full_q;
    wbank_d      = wbank_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    rbank_d      = rbank_q;
    rd_row_d     = rd_row_q;
    rd_col_d     = rd_col_q;
    blk_col_d    = blk_col_q;
    blk_cnt_d    = blk_cnt_q;
    out_pix_d    = out_pix_q;
    out_valid_d  = out_valid_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;
    out_blk_d    = out_blk_q;
    frame_done_d = out_valid_q && out_ready && out_last_q
                   && (out_blk_q == 5'(BlkPerFrame - 1));

    if (in_fire) begin
      if (wr_last) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = !wbank_q;
        wr_row_d        = '0;
        wr_col_d        = '0;
      end else if (wr_col_q == ColW'(IMG_W - 1)) begin
        wr_col_d = '0;
        wr_row_d = wr_row_q + 1'b1;
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end

    if (rd_load) begin
      out_pix_d   = rdata;
      out_valid_d = 1'b1;
      out_first_d = (rd_row_q == '0) && (rd_col_q == '0);
      out_last_d  = rd_blk_end;
      out_blk_d   = blk_cnt_q;
      rd_col_d    = rd_col_q + 1'b1;
      if (rd_col_q == RowW'(BLK - 1)) begin
        rd_col_d = '0;
        rd_row_d = rd_row_q + 1'b1;
      end
      if (rd_blk_end) begin
        rd_row_d  = '0;
        blk_col_d = blk_col_q + 1'b1;
        blk_cnt_d = (blk_cnt_q == 5'(BlkPerFrame - 1)) ? '0 : blk_cnt_q + 1'b1;
      end
      // Bank is released as soon as its final pixel sits in the output register.
      if (rd_strip_end) begin
        blk_col_d       = '0;
        full_d[rbank_q] = 1'b0;
        rbank_d         = !rbank_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q       <= '0;
      wbank_q      <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      rbank_q      <= 1'b0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      blk_col_q    <= '0;
      blk_cnt_q    <= '0;
      out_pix_q    <= '0;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_blk_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      full_q       <= full_d;
      wbank_q      <= wbank_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      rbank_q      <= rbank_d;
      rd_row_q     <= rd_row_d;
      rd_col_q     <= rd_col_d;
      blk_col_q    <= blk_col_d;
      blk_cnt_q    <= blk_cnt_d;
      out_pix_q    <= out_pix_d;
      out_valid_q  <= out_valid_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      out_blk_q    <= out_blk_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_pix    = out_pix_q;
  assign out_valid  = out_valid_q;
  assign out_first  = out_first_q;
  assign out_last   = out_last_q;
  assign out_blk    = out_blk_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_raster_to_block_tx.sv
// Directed bench for raster_to_block_tx: reorder, stalls, random flow control, latency, reset.
module tb_raster_to_block_tx;
  localparam int FramePix = 1536;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_pix = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_pix;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_first;
  logic       out_last;
  logic [4:0] out_blk;
  logic       frame_done;

  raster_to_block_tx dut (
    .clk        (clk),
    .reset      (reset),
    .in_pix     (in_pix),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_pix    (out_pix),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_first  (out_first),
    .out_last   (out_last),
    .out_blk    (out_blk),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus modes: 0 off, 1 always, 2 random 50%.
  int vmode = 0, rmode = 0, in_limit = 0;
  int in_idx, out_idx, in_total, out_total, fd_cnt;
  int cyc = 0, acc_edge, first_ov_cyc, first_ov_pix, pix63, last63;
  int first_vals [16];
  int exp16 [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 48, 49, 50, 51, 52, 53, 54, 55};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {first, last, blk, pix} for output k of a frame, from raster pixel (y*48+x) mod 256.
  function automatic logic [31:0] exp_out(input int k);
    int blk, r, c, y, x;
    logic [4:0] b5;
    logic [7:0] p8;
    blk = k / 64;
    r   = (k % 64) / 8;
    c   = k % 8;
    y   = (blk / 6) * 8 + r;
    x   = (blk % 6) * 8 + c;
    b5  = 5'(blk);
    p8  = 8'((y * 48 + x) % 256);
    return {17'd0, (k % 64 == 0), (k % 64 == 63), b5, p8};
  endfunction

  task automatic model_reset();
    in_idx = 0; out_idx = 0; in_total = 0; out_total = 0; fd_cnt = 0;
    acc_edge = -1; first_ov_cyc = -1; first_ov_pix = -1; pix63 = -1; last63 = -1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      in_valid  = (vmode == 1 || (vmode == 2 && $urandom_range(1) == 1)) && (in_total < in_limit);
      in_pix    = 8'(in_idx);
      out_ready = (rmode == 1) || (rmode == 2 && $urandom_range(1) == 1);
    end
  end

  // Handshakes are observed at the falling edge; they complete at the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) begin
        if (in_total == 383 && acc_edge < 0) acc_edge = cyc + 1;
        in_total++;
        in_idx = (in_idx + 1) % FramePix;
      end
      if (out_valid && first_ov_cyc < 0) begin
        first_ov_cyc = cyc;
        first_ov_pix = int'(out_pix);
      end
      if (out_valid && out_ready) begin
        check("out", {17'd0, out_first, out_last, out_blk, out_pix}, exp_out(out_idx));
        if (out_total < 16) first_vals[out_total] = int'(out_pix);
        if (out_total == 63) begin
          pix63  = int'(out_pix);
          last63 = int'(out_last);
        end
        out_total++;
        out_idx = (out_idx + 1) % FramePix;
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    vmode = 0;
    rmode = 0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (out_total >= n) break;
    end
    check("wait_out", 32'(out_total), 32'(n));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pix", 32'(out_pix), 32'd0);
    check("rst_first_last", {30'd0, out_first, out_last}, 32'd0);
    check("rst_out_blk", 32'(out_blk), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;

    // Unstalled single frame: ordering, latency, single frame_done.
    do_reset();
    in_limit = FramePix;
    vmode = 1;
    rmode = 1;
    wait_out(FramePix, 5000);
    repeat (4) @(negedge clk);
    #1;
    for (int i = 0; i < 16; i++) check("first16", 32'(first_vals[i]), 32'(exp16[i]));
    check("pix63", 32'(pix63), 32'd87);
    check("last63", 32'(last63), 32'd1);
    check("latency", 32'(first_ov_cyc), 32'(acc_edge + 1));
    check("lat_pix", 32'(first_ov_pix), 32'd0);
    check("frame_done_cnt", 32'(fd_cnt), 32'd1);
    check("idle_valid", 32'(out_valid), 32'd0);

    // Downstream stalled: both banks fill, head pixel holds.
    do_reset();
    in_limit = FramePix;
    vmode = 1;
    rmode = 0;
    repeat (800) @(negedge clk);
    #1;
    check("stall_accepts", 32'(in_total), 32'd768);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_pix", 32'(out_pix), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check("hold_pix", {22'd0, out_valid, out_first, out_blk, 3'd0}, {22'd0, 1'b1, 1'b1, 5'd0, 3'd0});
    check("hold_pix_val", 32'(out_pix), 32'd0);
    rmode = 1;
    wait_out(FramePix, 5000);
    repeat (4) @(negedge clk);
    check("stall_in_total", 32'(in_total), 32'(FramePix));
    check("stall_fd", 32'(fd_cnt), 32'd1);

    // Random flow control over three frames.
    do_reset();
    in_limit = 3 * FramePix;
    vmode = 2;
    rmode = 2;
    wait_out(3 * FramePix, 40000);
    vmode = 0;
    rmode = 1;
    repeat (6) @(negedge clk);
    check("rand_fd", 32'(fd_cnt), 32'd3);
    check("rand_extra", 32'(out_total), 32'(3 * FramePix));

    // Mid-frame reset, then a fresh frame from pixel (0,0).
    do_reset();
    in_limit = FramePix;
    vmode = 1;
    rmode = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (out_total >= 10 && in_total >= 200) break;
    end
    check("pre_reset_out", 32'(out_total >= 10), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    vmode = 0;
    rmode = 0;
    model_reset();
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_blk", 32'(out_blk), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    in_limit = FramePix;
    vmode = 1;
    rmode = 1;
    wait_out(FramePix, 5000);
    repeat (4) @(negedge clk);
    check("post_rst_fd", 32'(fd_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
